// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline.
// ALU op codes, branch codes and the decode-to-execute control bundle.
package riscv_pkg;

    localparam int REG_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_BLT  = 2'b11
    } br_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             alu_src;
        logic [2:0]       alu_control;
        logic             reg_write;
        br_e              branch;
    } id_ex_t;

endpackage

// File: rtl/ex_forward.sv
// Operand forwarding from the M register into the execute stage.
// Pure combinational compare and select.
module ex_forward
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             m_valid,
    input  logic             m_reg_write,
    input  logic [REG_W-1:0] m_rd,
    input  logic [WIDTH-1:0] m_result,
    input  logic [REG_W-1:0] e_rs,
    input  logic [WIDTH-1:0] e_val,
    output logic [WIDTH-1:0] fwd_val
);

    logic hit;

    // x0 is hard-wired to zero, so it never forwards.
    assign hit = m_valid && m_reg_write
              && (m_rd != '0) && (m_rd == e_rs);

    assign fwd_val = hit ? m_result : e_val;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select/forwarding, branch resolution,
// and the M output register towards the memory stage.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_alu_src,
    input  logic [2:0]       in_alu_control,
    input  logic             in_reg_write,
    input  logic [1:0]       in_branch,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [REG_W-1:0] out_rd,
    output logic             out_reg_write,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    logic             e_valid;
    logic [WIDTH-1:0] e_pc;
    logic [WIDTH-1:0] e_rs1_val;
    logic [WIDTH-1:0] e_rs2_val;
    logic [WIDTH-1:0] e_imm;
    id_ex_t           e_ctl;

    logic             m_valid;
    logic [WIDTH-1:0] m_result;
    logic [REG_W-1:0] m_rd;
    logic             m_reg_write;

    logic             e_fire;
    logic             taken;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;

    assign e_fire   = e_valid && (!m_valid || out_ready);
    assign in_ready = !e_valid || e_fire;

    ex_forward #(.WIDTH(WIDTH)) u_fwd_rs1 (
        .m_valid     (m_valid),
        .m_reg_write (m_reg_write),
        .m_rd        (m_rd),
        .m_result    (m_result),
        .e_rs        (e_ctl.rs1),
        .e_val       (e_rs1_val),
        .fwd_val     (fwd_rs1)
    );

    ex_forward #(.WIDTH(WIDTH)) u_fwd_rs2 (
        .m_valid     (m_valid),
        .m_reg_write (m_reg_write),
        .m_rd        (m_rd),
        .m_result    (m_result),
        .e_rs        (e_ctl.rs2),
        .e_val       (e_rs2_val),
        .fwd_val     (fwd_rs2)
    );

    assign alu_a       = fwd_rs1;
    assign alu_b       = e_ctl.alu_src ? e_imm : fwd_rs2;
    assign alu_control = e_ctl.alu_control;

    always_comb begin
        taken = 1'b0;
        unique case (e_ctl.branch)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = !alu_zero;
            BR_BLT:  taken = alu_result[0];
        endcase
    end

    assign redirect_valid = e_fire && taken;
    assign redirect_pc    = e_pc + e_imm;

    // A taken branch squashes whatever decode hands over this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid   <= 1'b0;
            e_pc      <= '0;
            e_rs1_val <= '0;
            e_rs2_val <= '0;
            e_imm     <= '0;
            e_ctl     <= '0;
        end else if (redirect_valid) begin
            e_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            e_valid         <= 1'b1;
            e_pc            <= in_pc;
            e_rs1_val       <= in_rs1_val;
            e_rs2_val       <= in_rs2_val;
            e_imm           <= in_imm;
            e_ctl.rs1       <= in_rs1;
            e_ctl.rs2       <= in_rs2;
            e_ctl.rd        <= in_rd;
            e_ctl.alu_src   <= in_alu_src;
            e_ctl.alu_control <= in_alu_control;
            e_ctl.reg_write <= in_reg_write;
            e_ctl.branch    <= br_e'(in_branch);
        end else if (e_fire) begin
            e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid     <= 1'b0;
            m_result    <= '0;
            m_rd        <= '0;
            m_reg_write <= 1'b0;
        end else if (e_fire) begin
            m_valid     <= (e_ctl.branch == BR_NONE);
            m_result    <= alu_result;
            m_rd        <= e_ctl.rd;
            m_reg_write <= e_ctl.reg_write;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign out_valid     = m_valid;
    assign out_result    = m_result;
    assign out_rd        = m_rd;
    assign out_reg_write = m_reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a behavioural stand-in ALU.
// Each check is an immediate assertion against a hand-computed value.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_alu_src;
    logic [2:0]  in_alu_control;
    logic        in_reg_write;
    logic [1:0]  in_branch;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_val     (in_rs1_val),
        .in_rs2_val     (in_rs2_val),
        .in_imm         (in_imm),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .in_alu_src     (in_alu_src),
        .in_alu_control (in_alu_control),
        .in_reg_write   (in_reg_write),
        .in_branch      (in_branch),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_control    (alu_control),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Core-level ALU that the stage drives
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b110: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [31:0] rs1v, input logic [4:0] rs2,
                         input logic [31:0] rs2v, input logic [31:0] imm,
                         input logic [4:0] rd, input logic src,
                         input logic [2:0] ctrl, input logic rw,
                         input logic [1:0] br);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_rs1         = rs1;
        in_rs1_val     = rs1v;
        in_rs2         = rs2;
        in_rs2_val     = rs2v;
        in_imm         = imm;
        in_rd          = rd;
        in_alu_src     = src;
        in_alu_control = ctrl;
        in_reg_write   = rw;
        in_branch      = br;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_redirect", {31'd0, redirect_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_result", out_result, 0);
        tick();
        reset = 1'b0;

        // ADDI x3 = 5 + 7
        drive(0, 2, 5, 0, 0, 7, 3, 1, 3'b000, 1, 2'b00);
        #1 chk("addi_in_ready", {31'd0, in_ready}, 1);
        tick();
        idle();
        #1 chk("addi_not_yet", {31'd0, out_valid}, 0);
        tick();
        chk("addi_valid", {31'd0, out_valid}, 1);
        chk("addi_result", out_result, 12);
        chk("addi_rd", {27'd0, out_rd}, 3);
        chk("addi_rw", {31'd0, out_reg_write}, 1);
        tick();
        chk("addi_drain", {31'd0, out_valid}, 0);

        // ADD x1 = 2 + 3, then SUB x5 = x1 - 1 with stale rs1 value
        drive(0, 2, 2, 3, 3, 0, 1, 0, 3'b000, 1, 2'b00);
        tick();
        drive(0, 1, 0, 4, 1, 0, 5, 0, 3'b001, 1, 2'b00);
        tick();
        idle();
        #1;
        chk("fwd_m_result", out_result, 5);
        chk("fwd_alu_a", alu_a, 5);
        tick();
        chk("fwd_sub_result", out_result, 4);
        chk("fwd_sub_rd", {27'd0, out_rd}, 5);
        tick();

        // BEQ taken with a same-cycle instruction that must be squashed
        drive(32'h100, 6, 9, 7, 9, 32'h20, 0, 0, 3'b001, 0, 2'b01);
        tick();
        drive(0, 0, 1, 0, 0, 1, 9, 1, 3'b000, 1, 2'b00);
        #1;
        chk("beq_redirect", {31'd0, redirect_valid}, 1);
        chk("beq_pc", redirect_pc, 32'h120);
        tick();
        idle();
        #1;
        chk("beq_pulse_end", {31'd0, redirect_valid}, 0);
        chk("beq_no_out", {31'd0, out_valid}, 0);
        tick();
        chk("squash_no_out", {31'd0, out_valid}, 0);

        // BNE on equal values is not taken
        drive(32'h100, 6, 9, 7, 9, 32'h20, 0, 0, 3'b001, 0, 2'b10);
        tick();
        idle();
        #1 chk("bne_not_taken", {31'd0, redirect_valid}, 0);
        tick();
        chk("bne_no_out", {31'd0, out_valid}, 0);

        // Backpressure: three ADDIs with out_ready low
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 10, 10, 1, 3'b000, 1, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 11, 11, 1, 3'b000, 1, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 12, 12, 1, 3'b000, 1, 2'b00);
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 0);
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        chk("bp_result0", out_result, 10);
        tick();
        chk("bp_hold_ready", {31'd0, in_ready}, 0);
        chk("bp_result1", out_result, 10);
        tick();
        chk("bp_result2", out_result, 10);
        chk("bp_rd2", {27'd0, out_rd}, 10);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 1);
        tick();
        idle();
        #1;
        chk("bp_second", out_result, 11);
        chk("bp_second_valid", {31'd0, out_valid}, 1);
        tick();
        chk("bp_third", out_result, 12);
        chk("bp_third_rd", {27'd0, out_rd}, 12);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 0);

        // rd = 0 in M must not forward to rs1 = 0 in E
        drive(0, 0, 0, 0, 0, 99, 0, 1, 3'b000, 1, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 5, 13, 1, 3'b000, 1, 2'b00);
        tick();
        idle();
        #1 chk("x0_no_fwd", alu_a, 0);
        tick();
        chk("x0_result", out_result, 5);
        tick();

        // BLT 3 < 7 taken
        drive(32'h200, 1, 3, 2, 7, 32'h40, 0, 0, 3'b101, 0, 2'b11);
        tick();
        idle();
        #1;
        chk("blt_taken", {31'd0, redirect_valid}, 1);
        chk("blt_pc", redirect_pc, 32'h240);
        tick();

        // Branch target wraps modulo 2^32
        drive(32'hFFFF_FFF0, 1, 4, 2, 4, 32'h20, 0, 0, 3'b001, 0, 2'b01);
        tick();
        idle();
        #1;
        chk("wrap_taken", {31'd0, redirect_valid}, 1);
        chk("wrap_pc", redirect_pc, 32'h10);
        tick();

        // Reset with M and E both full
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 1, 1, 3'b000, 1, 2'b00);
        tick();
        drive(32'h40, 1, 2, 2, 2, 32'h8, 0, 0, 3'b001, 0, 2'b01);
        tick();
        idle();
        #1 chk("pre_rst_stall", {31'd0, in_ready}, 0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_redirect", {31'd0, redirect_valid}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, out_valid}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
